// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate extender (sign/zero/upper/branch) behind a 2-entry valid/ready buffer
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  Instr,
    input  logic [1:0]       ExtMode,
    input  logic             InValid,
    output logic             InReady,
    output logic [OUT_W-1:0] SignImm,
    output logic             OutValid,
    input  logic             OutReady
);

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;

    logic [OUT_W-1:0] r_mem [2];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;

    assign w_sext = {{(OUT_W-IN_W){Instr[IN_W-1]}}, Instr};

    always_comb begin
        w_ext = '0;
        case (ExtMode)
            2'b00:   w_ext = w_sext;
            2'b01:   w_ext = {{(OUT_W-IN_W){1'b0}}, Instr};
            2'b10:   w_ext = {Instr, {(OUT_W-IN_W){1'b0}}};
            default: w_ext = {w_sext[OUT_W-3:0], 2'b00};
        endcase
    end

    // Readiness comes from registered occupancy only, so no ready path runs through the block.
    assign InReady  = reset_n && (r_count < 2'd2);
    assign OutValid = (r_count != 2'd0);
    assign SignImm  = OutValid ? r_mem[r_head] : '0;

    assign w_push = InValid && InReady;
    assign w_pop  = OutValid && OutReady;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_ext;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;

    logic        clk;
    logic        reset_n;
    logic [15:0] Instr;
    logic [1:0]  ExtMode;
    logic        InValid;
    logic        InReady;
    logic [31:0] SignImm;
    logic        OutValid;
    logic        OutReady;

    logic [11:0] s_instr;
    logic [1:0]  s_mode;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [15:0] s_sign_imm;
    logic        s_out_valid;
    logic        s_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Instr    (Instr),
        .ExtMode  (ExtMode),
        .InValid  (InValid),
        .InReady  (InReady),
        .SignImm  (SignImm),
        .OutValid (OutValid),
        .OutReady (OutReady)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(16)) u_dut_small (
        .clk      (clk),
        .reset_n  (reset_n),
        .Instr    (s_instr),
        .ExtMode  (s_mode),
        .InValid  (s_in_valid),
        .InReady  (s_in_ready),
        .SignImm  (s_sign_imm),
        .OutValid (s_out_valid),
        .OutReady (s_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [1:0] m);
        InValid = v;
        Instr   = ins;
        ExtMode = m;
    endtask

    logic [15:0] bb_ins [4];
    logic [1:0]  bb_mode [4];
    logic [31:0] bb_exp [4];

    initial begin
        bb_ins[0] = 16'h8001; bb_mode[0] = 2'b01; bb_exp[0] = 32'h0000_8001;
        bb_ins[1] = 16'h1234; bb_mode[1] = 2'b10; bb_exp[1] = 32'h1234_0000;
        bb_ins[2] = 16'hFFFF; bb_mode[2] = 2'b11; bb_exp[2] = 32'hFFFF_FFFC;
        bb_ins[3] = 16'h0004; bb_mode[3] = 2'b11; bb_exp[3] = 32'h0000_0010;

        reset_n = 1'b0;
        drive(1'b0, 16'h0, 2'b00);
        OutReady = 1'b0;
        s_instr = '0; s_mode = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_inready", 32'(InReady), 32'd0);
        check("rst_outvalid", 32'(OutValid), 32'd0);
        check("rst_signimm", SignImm, 32'd0);
        reset_n = 1'b1;

        // single push, sign extend
        @(negedge clk);
        check("idle_inready", 32'(InReady), 32'd1);
        check("idle_ready_no_pop", 32'(OutValid), 32'd0);
        drive(1'b1, 16'h8001, 2'b00);
        OutReady = 1'b1;
        @(negedge clk);
        check("single_valid", 32'(OutValid), 32'd1);
        check("single_data", SignImm, 32'hFFFF_8001);
        drive(1'b0, 16'h0, 2'b00);
        @(negedge clk);
        check("single_empty_valid", 32'(OutValid), 32'd0);
        check("single_empty_data", SignImm, 32'd0);

        // back-to-back, all modes
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, bb_ins[k], bb_mode[k]);
            @(negedge clk);
            check($sformatf("b2b_valid_%0d", k), 32'(OutValid), 32'd1);
            check($sformatf("b2b_data_%0d", k), SignImm, bb_exp[k]);
        end
        drive(1'b0, 16'h0, 2'b00);
        @(negedge clk);
        check("b2b_drain", 32'(OutValid), 32'd0);

        // fill with backpressure
        OutReady = 1'b0;
        drive(1'b1, 16'h0001, 2'b00);
        @(negedge clk);
        check("fill_ready_c1", 32'(InReady), 32'd1);
        drive(1'b1, 16'h8000, 2'b01);
        @(negedge clk);
        check("fill_ready_c2", 32'(InReady), 32'd0);
        drive(1'b1, 16'h00FF, 2'b10);
        @(negedge clk);
        check("full_ready_held", 32'(InReady), 32'd0);
        check("full_head_stable", SignImm, 32'h0000_0001);
        drive(1'b1, 16'h1111, 2'b11);
        @(negedge clk);
        check("full_head_stable2", SignImm, 32'h0000_0001);
        drive(1'b1, 16'h00FF, 2'b10);
        OutReady = 1'b1;
        @(negedge clk);
        check("drain_a_then_b", SignImm, 32'h0000_8000);
        check("drain_ready_back", 32'(InReady), 32'd1);
        @(negedge clk);
        check("drain_c", SignImm, 32'h00FF_0000);
        check("drain_c_valid", 32'(OutValid), 32'd1);
        drive(1'b0, 16'h0, 2'b00);
        @(negedge clk);
        check("drain_empty", 32'(OutValid), 32'd0);

        // Count=1 with simultaneous push and pop
        OutReady = 1'b0;
        drive(1'b1, 16'h0100, 2'b01);
        @(negedge clk);
        check("steady_head_0", SignImm, 32'h0000_0100);
        OutReady = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 16'h0100 + 16'(k), 2'b01);
            @(negedge clk);
            check($sformatf("steady_valid_%0d", k), 32'(OutValid), 32'd1);
            check($sformatf("steady_data_%0d", k), SignImm, 32'h0000_0100 + 32'(k));
            check($sformatf("steady_ready_%0d", k), 32'(InReady), 32'd1);
        end
        drive(1'b0, 16'h0, 2'b00);
        @(negedge clk);
        check("steady_drain", 32'(OutValid), 32'd0);

        // asynchronous reset with buffer full
        OutReady = 1'b0;
        drive(1'b1, 16'h1234, 2'b00);
        repeat (2) @(negedge clk);
        check("pre_reset_full", 32'(InReady), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(OutValid), 32'd0);
        check("async_rst_data", SignImm, 32'd0);
        check("async_rst_ready", 32'(InReady), 32'd0);
        drive(1'b0, 16'h0, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        OutReady = 1'b1;
        drive(1'b1, 16'h7FFF, 2'b00);
        @(negedge clk);
        check("post_rst_valid", 32'(OutValid), 32'd1);
        check("post_rst_data", SignImm, 32'h0000_7FFF);
        drive(1'b0, 16'h0, 2'b00);
        @(negedge clk);
        check("post_rst_empty", 32'(OutValid), 32'd0);

        // narrow instance
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_instr = 12'h800; s_mode = 2'b11;
        @(negedge clk);
        check("small_branch", 32'(s_sign_imm), 32'h0000_E000);
        s_instr = 12'hABC; s_mode = 2'b10;
        @(negedge clk);
        check("small_upper", 32'(s_sign_imm), 32'h0000_ABC0);
        s_instr = 12'hABC; s_mode = 2'b00;
        @(negedge clk);
        check("small_sign", 32'(s_sign_imm), 32'h0000_FABC);
        s_in_valid = 1'b0;
        @(negedge clk);
        check("small_empty", 32'(s_out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
